// File: rtl/l2_arbiter.sv
// Arbitrates the single L2 port between the I-side prefetcher and the D-cache.
// One transaction in flight, alternating priority on ties, saturating per-side grant counters.
module l2_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,

    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_e;

    state_e            state_q,    state_d;
    logic              last_d_q,   last_d_d;   // 1 when the D-side was the most recent winner
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [LINE_W-1:0] wdata_q,    wdata_d;
    logic              l2_read_q,  l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [CNT_W-1:0]  i_cnt_q,    i_cnt_d;
    logic [CNT_W-1:0]  d_cnt_q,    d_cnt_d;

    logic i_req;
    logic d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Read data is a plain pass-through; only the resp pulse qualifies it.
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    // An L2 completion is only meaningful while a side is being served.
    assign i_resp = !reset && (state_q == SERVE_I) && l2_resp;
    assign d_resp = !reset && (state_q == SERVE_D) && l2_resp;

    assign l2_read     = l2_read_q;
    assign l2_write    = l2_write_q;
    assign l2_address  = addr_q;
    assign l2_wdata    = wdata_q;
    assign i_grant_cnt = i_cnt_q;
    assign d_grant_cnt = d_cnt_q;

    // NOTE: every _d starts from its _q so no path through the case leaves a signal unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        i_cnt_d    = i_cnt_q;
        d_cnt_d    = d_cnt_q;

        case (state_q)
            IDLE: begin
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
                if (i_req && (!d_req || last_d_q)) begin
                    state_d   = SERVE_I;
                    addr_d    = i_address;
                    l2_read_d = 1'b1;
                end else if (d_req) begin
                    // A simultaneous read and write from the D-side is a writeback.
                    state_d    = SERVE_D;
                    addr_d     = d_address;
                    wdata_d    = d_wdata;
                    l2_write_d = d_write;
                    l2_read_d  = !d_write;
                end
            end

            SERVE_I: begin
                if (l2_resp) begin
                    state_d    = RELEASE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    last_d_d   = 1'b0;
                    i_cnt_d    = (&i_cnt_q) ? i_cnt_q : i_cnt_q + CNT_W'(1);
                end
            end

            SERVE_D: begin
                if (l2_resp) begin
                    state_d    = RELEASE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    last_d_d   = 1'b1;
                    d_cnt_d    = (&d_cnt_q) ? d_cnt_q : d_cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                // Requests are deliberately not sampled here so a client that just got
                // its resp has one cycle to drop its request before arbitration resumes.
                state_d    = IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end

            default: begin
                state_d    = IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            i_cnt_q    <= '0;
            d_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            i_cnt_q    <= i_cnt_d;
            d_cnt_q    <= d_cnt_d;
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected L2 requests and responses are queued when stimulus
// is driven and checked by a negedge monitor; a small-counter instance covers saturation.
module tb_l2_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;

    // Saturation instance: narrow counters, L2 answers in the first serve cycle.
    logic              sat_reset;
    logic              sat_i_read;
    logic [LINE_W-1:0] sat_i_rdata;
    logic              sat_i_resp;
    logic [LINE_W-1:0] sat_d_rdata;
    logic              sat_d_resp;
    logic              sat_l2_read;
    logic              sat_l2_write;
    logic [ADDR_W-1:0] sat_l2_address;
    logic [LINE_W-1:0] sat_l2_wdata;
    logic              sat_l2_resp;
    logic [SAT_W-1:0]  sat_i_cnt;
    logic [SAT_W-1:0]  sat_d_cnt;

    assign sat_l2_resp = sat_l2_read;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic              is_d;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_strobe_prev = 1'b0;

    localparam logic [LINE_W-1:0] IDLE_RDATA = {8{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    l2_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    l2_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) sat (
        .clk(clk), .reset(sat_reset),
        .i_read(sat_i_read), .i_address(16'h0080), .i_rdata(sat_i_rdata), .i_resp(sat_i_resp),
        .d_read(1'b0), .d_write(1'b0), .d_address(16'h0000), .d_wdata('0),
        .d_rdata(sat_d_rdata), .d_resp(sat_d_resp),
        .l2_read(sat_l2_read), .l2_write(sat_l2_write), .l2_address(sat_l2_address),
        .l2_wdata(sat_l2_wdata), .l2_rdata({8{32'h5A5A_0001}}), .l2_resp(sat_l2_resp),
        .i_grant_cnt(sat_i_cnt), .d_grant_cnt(sat_d_cnt)
    );

    // Monitor: L2 request contents on each new strobe, response side/data on each resp pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if ((l2_read || l2_write) && !mon_strobe_prev) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL l2_req_unexpected: got rd=%b wr=%b addr=%h, expected no request",
                             l2_read, l2_write, l2_address);
                end else if (l2_address !== exp_q[0].addr || l2_write !== exp_q[0].wr ||
                             l2_read !== !exp_q[0].wr ||
                             (exp_q[0].wr && l2_wdata !== exp_q[0].wdata)) begin
                    miscompares++;
                    $display("FAIL l2_req: got rd=%b wr=%b addr=%h, expected wr=%b addr=%h",
                             l2_read, l2_write, l2_address, exp_q[0].wr, exp_q[0].addr);
                end
            end
            if (i_resp && d_resp) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_both: i_resp and d_resp high together, expected at most one");
            end else if (i_resp || d_resp) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL resp_unexpected: got i_resp=%b d_resp=%b, expected none", i_resp, d_resp);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_d !== d_resp || (d_resp ? d_rdata : i_rdata) !== mon_e.rdata) begin
                        miscompares++;
                        $display("FAIL resp: got d_side=%b rdata=%h, expected d_side=%b rdata=%h",
                                 d_resp, (d_resp ? d_rdata : i_rdata), mon_e.is_d, mon_e.rdata);
                    end
                end
            end
        end
        mon_strobe_prev = l2_read || l2_write;
    end

    task automatic push_exp(input logic is_d, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        l2_resp = 1'b0; l2_rdata = IDLE_RDATA;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Cycles waited until a strobe is visible; a missing strobe is a miscompare.
    task automatic wait_strobe(output int n);
        n = 0;
        while (!(l2_read || l2_write) && n < 50) begin
            tick();
            n++;
        end
        if (!(l2_read || l2_write)) begin
            vectors++;
            miscompares++;
            $display("FAIL strobe_timeout: got no L2 strobe after %0d cycles, expected one", n);
        end
    endtask

    task automatic l2_respond(input int lat, input logic [LINE_W-1:0] data);
        int n;
        wait_strobe(n);
        repeat (lat - 1) tick();
        l2_rdata = data;
        l2_resp  = 1'b1;
        tick();
        l2_resp  = 1'b0;
        l2_rdata = IDLE_RDATA;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, expected 0000", {l2_read, l2_write, i_resp, d_resp});
        end
        vectors++;
        if (i_grant_cnt !== '0 || d_grant_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got i=%h d=%h, expected 0 0", i_grant_cnt, d_grant_cnt);
        end
        vectors++;
        if (l2_address !== '0 || l2_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_latch: got addr=%h wdata=%h, expected 0", l2_address, l2_wdata);
        end
    endtask

    task automatic test_single_i();
        logic [LINE_W-1:0] a5 = {32{8'hA5}};
        int n;
        apply_reset();
        push_exp(1'b0, 1'b0, 16'h0040, '0, a5);
        i_read = 1'b1; i_address = 16'h0040;
        wait_strobe(n);
        vectors++;
        if (n !== 1 || l2_read !== 1'b1 || l2_address !== 16'h0040) begin
            miscompares++;
            $display("FAIL single_latency: got n=%0d rd=%b addr=%h, expected 1 1 0040", n, l2_read, l2_address);
        end
        repeat (2) tick();
        vectors++;
        if (i_resp !== 1'b0 || l2_read !== 1'b1) begin
            miscompares++;
            $display("FAIL single_hold: got i_resp=%b rd=%b, expected 0 1", i_resp, l2_read);
        end
        l2_rdata = a5; l2_resp = 1'b1;
        #1;
        vectors++;
        if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== a5) begin
            miscompares++;
            $display("FAIL single_resp: got i_resp=%b d_resp=%b rdata=%h, expected 1 0 a5..",
                     i_resp, d_resp, i_rdata);
        end
        tick();
        l2_resp = 1'b0; l2_rdata = IDLE_RDATA; i_read = 1'b0;
        vectors++;
        if (l2_read !== 1'b0 || i_grant_cnt !== 16'd1 || d_grant_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL single_done: got rd=%b i_cnt=%0d d_cnt=%0d, expected 0 1 0",
                     l2_read, i_grant_cnt, d_grant_cnt);
        end
        repeat (2) tick();
        vectors++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
            miscompares++;
            $display("FAIL single_reserve: got rd=%b wr=%b, expected 0 0", l2_read, l2_write);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        // Fresh reset: I wins, then D.
        push_exp(1'b0, 1'b0, 16'h0100, '0, {8{32'h1111_0001}});
        push_exp(1'b1, 1'b0, 16'h0200, '0, {8{32'h2222_0002}});
        i_read = 1'b1; i_address = 16'h0100;
        d_read = 1'b1; d_address = 16'h0200;
        l2_respond(2, {8{32'h1111_0001}});
        i_read = 1'b0;
        l2_respond(2, {8{32'h2222_0002}});
        d_read = 1'b0;
        // A lone I transaction leaves I as last winner, so the next tie goes D then I.
        push_exp(1'b0, 1'b0, 16'h0300, '0, {8{32'h3333_0003}});
        i_read = 1'b1; i_address = 16'h0300;
        l2_respond(1, {8{32'h3333_0003}});
        i_read = 1'b0;
        tick();
        push_exp(1'b1, 1'b0, 16'h0400, '0, {8{32'h4444_0004}});
        push_exp(1'b0, 1'b0, 16'h0500, '0, {8{32'h5555_0005}});
        i_read = 1'b1; i_address = 16'h0500;
        d_read = 1'b1; d_address = 16'h0400;
        l2_respond(3, {8{32'h4444_0004}});
        d_read = 1'b0;
        l2_respond(2, {8{32'h5555_0005}});
        i_read = 1'b0;
        tick();
        vectors++;
        if (i_grant_cnt !== 16'd3 || d_grant_cnt !== 16'd2 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL tie_counts: got i=%0d d=%0d pending=%0d, expected 3 2 0",
                     i_grant_cnt, d_grant_cnt, exp_q.size());
        end
    endtask

    task automatic test_spurious();
        // Runs after test_tie without reset: counters are 3 and 2, state IDLE.
        l2_rdata = {8{32'hCAFE_0000}}; l2_resp = 1'b1;
        #1;
        vectors++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_resp: got i=%b d=%b, expected 0 0", i_resp, d_resp);
        end
        tick();
        l2_resp = 1'b0; l2_rdata = IDLE_RDATA;
        tick();
        vectors++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0 || i_grant_cnt !== 16'd3 || d_grant_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL spurious_state: got rd=%b wr=%b i=%0d d=%0d, expected 0 0 3 2",
                     l2_read, l2_write, i_grant_cnt, d_grant_cnt);
        end
    endtask

    task automatic test_dwrite();
        logic [LINE_W-1:0] w = {16{16'h1234}};
        int n;
        apply_reset();
        push_exp(1'b1, 1'b1, 16'h1F00, w, {8{32'h7777_0007}});
        // Read and write together must be treated as a write.
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h1F00; d_wdata = w;
        wait_strobe(n);
        vectors++;
        if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== w) begin
            miscompares++;
            $display("FAIL dwrite_strobe: got rd=%b wr=%b wdata=%h, expected 0 1 1234..", l2_read, l2_write, l2_wdata);
        end
        d_address = 16'h0000; d_wdata = '0;
        repeat (2) tick();
        vectors++;
        if (l2_address !== 16'h1F00 || l2_wdata !== w || l2_write !== 1'b1) begin
            miscompares++;
            $display("FAIL dwrite_latch: got addr=%h wr=%b, expected 1f00 1", l2_address, l2_write);
        end
        l2_rdata = {8{32'h7777_0007}}; l2_resp = 1'b1;
        #1;
        vectors++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL dwrite_resp: got d=%b i=%b, expected 1 0", d_resp, i_resp);
        end
        tick();
        l2_resp = 1'b0; l2_rdata = IDLE_RDATA;
        d_read = 1'b0; d_write = 1'b0;
        vectors++;
        if (d_grant_cnt !== 16'd1 || i_grant_cnt !== 16'd0 || l2_write !== 1'b0) begin
            miscompares++;
            $display("FAIL dwrite_done: got d=%0d i=%0d wr=%b, expected 1 0 0", d_grant_cnt, i_grant_cnt, l2_write);
        end
    endtask

    task automatic test_reset_mid_serve();
        int n;
        apply_reset();
        i_read = 1'b1; i_address = 16'h0600;
        push_exp(1'b0, 1'b0, 16'h0600, '0, {8{32'h6666_0006}});
        l2_respond(1, {8{32'h6666_0006}});
        i_read = 1'b0;
        tick();
        push_exp(1'b1, 1'b1, 16'h2000, {8{32'h0BAD_F00D}}, '0);
        d_write = 1'b1; d_address = 16'h2000; d_wdata = {8{32'h0BAD_F00D}};
        wait_strobe(n);
        tick();
        reset = 1'b1; d_write = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
        vectors++;
        if (l2_write !== 1'b0 || l2_read !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_strobe: got rd=%b wr=%b d_resp=%b, expected 0 0 0", l2_read, l2_write, d_resp);
        end
        vectors++;
        if (i_grant_cnt !== '0 || d_grant_cnt !== '0) begin
            miscompares++;
            $display("FAIL abort_cnt: got i=%0d d=%0d, expected 0 0", i_grant_cnt, d_grant_cnt);
        end
        l2_resp = 1'b1;
        #1;
        vectors++;
        if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_late_resp: got d=%b i=%b, expected 0 0", d_resp, i_resp);
        end
        tick();
        l2_resp = 1'b0;
        tick();
        vectors++;
        if (d_grant_cnt !== '0 || i_grant_cnt !== '0 || l2_write !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_after: got d=%0d i=%0d wr=%b, expected 0 0 0", d_grant_cnt, i_grant_cnt, l2_write);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        apply_reset();
        for (int k = 0; k < 3; k++)
            push_exp(1'b0, 1'b0, 16'h0700, '0, {8{32'hB000_0000 + k}});
        i_read = 1'b1; i_address = 16'h0700;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(n);
            if (k > 0) begin
                vectors++;
                // RELEASE plus one IDLE cycle between completion and the next strobe.
                if (n !== 2) begin
                    miscompares++;
                    $display("FAIL b2b_gap: got %0d cycles, expected 2", n);
                end
            end
            l2_rdata = {8{32'hB000_0000 + k}}; l2_resp = 1'b1;
            tick();
            if (k == 0) begin
                // Held l2_resp now lands in RELEASE and must be ignored.
                #1;
                vectors++;
                if (i_resp !== 1'b0 || i_grant_cnt !== 16'd1) begin
                    miscompares++;
                    $display("FAIL release_resp: got i_resp=%b cnt=%0d, expected 0 1", i_resp, i_grant_cnt);
                end
            end
            l2_resp = 1'b0; l2_rdata = IDLE_RDATA;
        end
        i_read = 1'b0;
        tick();
        vectors++;
        if (i_grant_cnt !== 16'd3 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d pending=%0d, expected 3 0", i_grant_cnt, exp_q.size());
        end
    endtask

    task automatic sat_wait_resps(input int target, inout int k);
        int cyc = 0;
        while (k < target && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sat_i_resp) k++;
        end
        tick();
        if (k < target) begin
            vectors++;
            miscompares++;
            $display("FAIL sat_timeout: got %0d completions, expected %0d", k, target);
        end
    endtask

    task automatic test_saturation();
        int k = 0;
        sat_reset = 1'b1;
        repeat (2) tick();
        sat_reset = 1'b0;
        sat_i_read = 1'b1;
        sat_wait_resps(14, k);
        vectors++;
        if (sat_i_cnt !== 4'd14) begin
            miscompares++;
            $display("FAIL sat_14: got %0d, expected 14", sat_i_cnt);
        end
        sat_wait_resps(16, k);
        vectors++;
        if (sat_i_cnt !== 4'hF) begin
            miscompares++;
            $display("FAIL sat_16: got %h, expected f", sat_i_cnt);
        end
        sat_wait_resps(20, k);
        sat_i_read = 1'b0;
        vectors++;
        if (sat_i_cnt !== 4'hF || sat_d_cnt !== 4'h0) begin
            miscompares++;
            $display("FAIL sat_20: got i=%h d=%h, expected f 0", sat_i_cnt, sat_d_cnt);
        end
    endtask

    initial begin
        sat_reset = 1'b1; sat_i_read = 1'b0;
        reset = 1'b1;
        test_reset();
        test_single_i();
        test_tie();
        test_spurious();
        test_dwrite();
        test_reset_mid_serve();
        test_back_to_back();
        test_saturation();
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, expected bench to finish");
        $fatal(1);
    end

endmodule
